// File: rtl/seq100111_generator_pkg.sv
// Shared definitions for the 100111 pattern link (generator and detector).
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } seq_state_t;

    localparam logic [5:0] SEQ_PATTERN = 6'b100111;
    localparam int         SEQ_LEN     = 6;

endpackage

// File: rtl/seq100111_generator_if.sv
// Control and serial-output bundle of the pattern generator.
interface seq100111_generator_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] rep_count;
    logic             abort;
    logic             dout;
    logic             dout_valid;
    logic             frame_done;
    logic             busy;

    modport master (
        output start, rep_count, abort,
        input  dout, dout_valid, frame_done, busy
    );

    modport slave (
        input  start, rep_count, abort,
        output dout, dout_valid, frame_done, busy
    );
endinterface

// File: rtl/seq100111_generator.sv
// Serial 100111 pattern transmitter: N frames MSB-first with zero gap bits between them.
//
//  state | meaning
//  IDLE  | waiting for start; outputs low
//  SEND  | shifting out PATTERN[bit_idx], bit_idx counting down to 0
//  GAP   | GAP_LEN idle zero bits between frames, gap_cnt counting down to 0
//
// Outputs are registered from the current state, so the first frame bit shows
// one edge after the edge that accepts start.
module seq100111_generator
    import seq_pkg::*;
#(
    parameter logic [SEQ_LEN-1:0] PATTERN = SEQ_PATTERN,
    parameter int                 PAT_LEN = SEQ_LEN,
    parameter int                 GAP_LEN = 2,
    parameter int                 CNT_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    seq100111_generator_if.slave  bus
);

    localparam int IDX_W = $clog2(PAT_LEN);
    localparam int GAP_W = (GAP_LEN < 2) ? 1 : $clog2(GAP_LEN + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_LEN - 1);

    seq_state_t       state, state_nxt;
    logic [IDX_W-1:0] bit_idx, bit_idx_nxt;
    logic [CNT_W-1:0] frames_left, frames_left_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;

    logic dout_q, dout_nxt;
    logic valid_q, valid_nxt;
    logic done_q, done_nxt;
    logic busy_q, busy_nxt;

    // State, counters and registered outputs; async reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bit_idx     <= LAST_IDX;
            frames_left <= '0;
            gap_cnt     <= '0;
            dout_q      <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_idx     <= bit_idx_nxt;
            frames_left <= frames_left_nxt;
            gap_cnt     <= gap_cnt_nxt;
            dout_q      <= dout_nxt;
            valid_q     <= valid_nxt;
            done_q      <= done_nxt;
            busy_q      <= busy_nxt;
        end
    end

    // Next state, counter updates and next output values; abort overrides everything.
    always_comb begin
        state_nxt       = state;
        bit_idx_nxt     = bit_idx;
        frames_left_nxt = frames_left;
        gap_cnt_nxt     = gap_cnt;
        dout_nxt        = 1'b0;
        valid_nxt       = 1'b0;
        done_nxt        = 1'b0;
        busy_nxt        = 1'b0;

        if (bus.abort) begin
            state_nxt       = IDLE;
            bit_idx_nxt     = LAST_IDX;
            frames_left_nxt = '0;
            gap_cnt_nxt     = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_nxt       = SEND;
                        bit_idx_nxt     = LAST_IDX;
                        frames_left_nxt = (bus.rep_count == '0) ? CNT_W'(1) : bus.rep_count;
                    end
                end
                SEND: begin
                    dout_nxt  = PATTERN[bit_idx];
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                    if (bit_idx == '0) begin
                        done_nxt        = 1'b1;
                        frames_left_nxt = frames_left - CNT_W'(1);
                        bit_idx_nxt     = LAST_IDX;
                        if (frames_left == CNT_W'(1)) begin
                            state_nxt = IDLE;
                        end else if (GAP_LEN == 0) begin
                            state_nxt = SEND;
                        end else begin
                            state_nxt   = GAP;
                            gap_cnt_nxt = GAP_W'(GAP_LEN - 1);
                        end
                    end else begin
                        bit_idx_nxt = bit_idx - IDX_W'(1);
                    end
                end
                GAP: begin
                    busy_nxt = 1'b1;
                    if (gap_cnt == '0) begin
                        state_nxt   = SEND;
                        bit_idx_nxt = LAST_IDX;
                    end else begin
                        gap_cnt_nxt = gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state_nxt   = IDLE;
                    bit_idx_nxt = LAST_IDX;
                end
            endcase
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.frame_done = done_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_seq100111_generator.sv
// Bench for the 100111 generator: two instances (gap 2 and gap 0) driven with the same
// stimulus and compared every cycle against a frame-stream reference model.
module tb_seq100111_generator;

    logic clk;
    logic reset;

    seq100111_generator_if #(.CNT_W(4)) bus2 ();
    seq100111_generator_if #(.CNT_W(4)) bus0 ();

    seq100111_generator #(.GAP_LEN(2), .CNT_W(4)) u_dut_gap2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    seq100111_generator #(.GAP_LEN(0), .CNT_W(4)) u_dut_gap0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // expected per-cycle outputs packed as {dout, dout_valid, frame_done, busy}
    logic [3:0] q2[$];
    logic [3:0] q0[$];
    logic [5:0] pat = 6'b100111;

    int hits2, hits0, busy2, busy0, done2, done0;
    logic [5:0] sr2, sr0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr_stats();
        hits2 = 0; hits0 = 0; busy2 = 0; busy0 = 0; done2 = 0; done0 = 0;
        sr2 = '0; sr0 = '0;
    endtask

    // Full output stream of one accepted request: n frames, g zero bits between frames.
    task automatic push_stream(input int sel, input int n, input int g);
        logic [3:0] e;
        for (int f = 0; f < n; f++) begin
            for (int b = 5; b >= 0; b--) begin
                e = {pat[b], 1'b1, (b == 0), 1'b1};
                if (sel == 2) q2.push_back(e); else q0.push_back(e);
            end
            if (f < n - 1) begin
                for (int j = 0; j < g; j++) begin
                    if (sel == 2) q2.push_back(4'b0001); else q0.push_back(4'b0001);
                end
            end
        end
    endtask

    // Expected outputs after a clock edge, given the inputs present at that edge.
    task automatic model_step(input int sel, input logic s, input logic [3:0] r,
                              input logic a, output logic [3:0] e);
        int sz;
        int n;
        sz = (sel == 2) ? q2.size() : q0.size();
        e = 4'b0000;
        if (a) begin
            if (sel == 2) q2.delete(); else q0.delete();
        end else if (sz > 0) begin
            if (sel == 2) e = q2.pop_front(); else e = q0.pop_front();
        end else if (s) begin
            n = (r == 0) ? 1 : int'(r);
            push_stream(sel, n, sel);
        end
    endtask

    task automatic cycle(input logic s, input logic [3:0] r, input logic a);
        logic [3:0] e2, e0;
        @(negedge clk);
        bus2.start = s; bus2.rep_count = r; bus2.abort = a;
        bus0.start = s; bus0.rep_count = r; bus0.abort = a;
        @(posedge clk);
        model_step(2, s, r, a, e2);
        model_step(0, s, r, a, e0);
        #1;
        chk("gap2_out", {28'd0, bus2.dout, bus2.dout_valid, bus2.frame_done, bus2.busy}, {28'd0, e2});
        chk("gap0_out", {28'd0, bus0.dout, bus0.dout_valid, bus0.frame_done, bus0.busy}, {28'd0, e0});
        sr2 = {sr2[4:0], bus2.dout};
        sr0 = {sr0[4:0], bus0.dout};
        if (sr2 == pat) hits2++;
        if (sr0 == pat) hits0++;
        if (bus2.busy) busy2++;
        if (bus0.busy) busy0++;
        if (bus2.frame_done) done2++;
        if (bus0.frame_done) done0++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gap2"}, {28'd0, bus2.dout, bus2.dout_valid, bus2.frame_done, bus2.busy}, 32'd0);
        chk({tag, "_gap0"}, {28'd0, bus0.dout, bus0.dout_valid, bus0.frame_done, bus0.busy}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus2.start = 1'b0; bus2.rep_count = '0; bus2.abort = 1'b0;
        bus0.start = 1'b0; bus0.rep_count = '0; bus0.abort = 1'b0;
        #1;
        chk_zero("reset");
        q2.delete(); q0.delete();
        @(negedge clk);
        reset = 1'b0;
        clr_stats();
    endtask

    task automatic chk_stats(input string tag, input int h2, input int b2, input int h0, input int b0);
        chk({tag, "_hits2"}, hits2, h2);
        chk({tag, "_busy2"}, busy2, b2);
        chk({tag, "_done2"}, done2, h2);
        chk({tag, "_hits0"}, hits0, h0);
        chk({tag, "_busy0"}, busy0, b0);
        chk({tag, "_done0"}, done0, h0);
        clr_stats();
    endtask

    initial begin
        reset = 1'b0;
        clr_stats();
        do_reset();

        // single frame
        cycle(1'b1, 4'd1, 1'b0);
        idle(10);
        chk_stats("t1", 1, 6, 1, 6);

        // three frames
        cycle(1'b1, 4'd3, 1'b0);
        idle(30);
        chk_stats("t2", 3, 22, 3, 18);

        // zero count behaves as one
        cycle(1'b1, 4'd0, 1'b0);
        idle(10);
        chk_stats("t3", 1, 6, 1, 6);

        // two frames, back-to-back on the gap-0 instance
        cycle(1'b1, 4'd2, 1'b0);
        idle(20);
        chk_stats("t4", 2, 14, 2, 12);

        // start during 3rd bit is ignored
        cycle(1'b1, 4'd5, 1'b0);
        idle(2);
        cycle(1'b1, 4'd7, 1'b0);
        idle(60);
        chk_stats("t5", 5, 38, 5, 30);

        // abort while 4th bit is on dout
        cycle(1'b1, 4'd2, 1'b0);
        idle(4);
        cycle(1'b0, 4'd0, 1'b1);
        chk_zero("abort");
        idle(10);
        chk_stats("t6", 0, 4, 0, 4);

        // start and abort together in IDLE
        cycle(1'b1, 4'd3, 1'b1);
        idle(5);
        chk_stats("t6b", 0, 0, 0, 0);

        // async reset in the middle of the first gap
        cycle(1'b1, 4'd2, 1'b0);
        idle(7);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("async_rst");
        q2.delete(); q0.delete();
        @(negedge clk);
        reset = 1'b0;
        idle(5);
        clr_stats();

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 59) == 0));
        end
        idle(130);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
